// File: rtl/sysid_checker.sv
// Avalon-MM read master: fetches the system-ID word and build timestamp,
// compares both against the expected build and reports match/timeout.
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'd12345678,
    parameter logic [31:0] EXPECTED_TS    = 32'd1432141006,
    parameter int unsigned READ_LATENCY   = 0,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        start_i,
    output logic        avm_address_o,
    output logic        avm_read_o,
    input  logic        avm_waitrequest_i,
    input  logic [31:0] avm_readdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        id_ok_o,
    output logic        ts_ok_o,
    output logic        timeout_o,
    output logic [31:0] id_value_o,
    output logic [31:0] ts_value_o
);

    typedef enum logic [2:0] {IDLE, RD_ID, WT_ID, RD_TS, WT_TS, CMP, DONE} state_t;

    localparam logic [15:0] STALL_LIM = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]  LAT_LIM   = 3'(READ_LATENCY - 1);

    state_t      state_q, state_d;
    logic [15:0] stall_q, stall_d;
    logic [2:0]  lat_q, lat_d;
    logic [31:0] id_q, id_d, ts_q, ts_d;
    logic        id_ok_q, id_ok_d, ts_ok_q, ts_ok_d;
    logic        timeout_q, timeout_d;
    logic        auto_q, auto_d;
    logic        rd_ts;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            stall_q   <= '0;
            lat_q     <= '0;
            id_q      <= '0;
            ts_q      <= '0;
            id_ok_q   <= 1'b0;
            ts_ok_q   <= 1'b0;
            timeout_q <= 1'b0;
            auto_q    <= AUTO_START;
        end else begin
            state_q   <= state_d;
            stall_q   <= stall_d;
            lat_q     <= lat_d;
            id_q      <= id_d;
            ts_q      <= ts_d;
            id_ok_q   <= id_ok_d;
            ts_ok_q   <= ts_ok_d;
            timeout_q <= timeout_d;
            auto_q    <= auto_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        stall_d       = stall_q;
        lat_d         = lat_q;
        id_d          = id_q;
        ts_d          = ts_q;
        id_ok_d       = id_ok_q;
        ts_ok_d       = ts_ok_q;
        timeout_d     = timeout_q;
        auto_d        = auto_q;
        avm_read_o    = 1'b0;
        avm_address_o = 1'b0;
        rd_ts         = (state_q == RD_TS) || (state_q == WT_TS);

        case (state_q)
            IDLE, DONE: begin
                if (start_i || auto_q) begin
                    state_d   = RD_ID;
                    auto_d    = 1'b0;
                    stall_d   = '0;
                    id_ok_d   = 1'b0;
                    ts_ok_d   = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            RD_ID, RD_TS: begin
                avm_read_o    = 1'b1;
                avm_address_o = rd_ts;
                if (!avm_waitrequest_i) begin
                    stall_d = '0;
                    lat_d   = '0;
                    if (READ_LATENCY == 0) begin
                        if (rd_ts) ts_d = avm_readdata_i;
                        else       id_d = avm_readdata_i;
                        state_d = rd_ts ? CMP : RD_TS;
                    end else begin
                        state_d = rd_ts ? WT_TS : WT_ID;
                    end
                end else if (stall_q == STALL_LIM) begin
                    // Abandon the read; any word not yet fetched reads back as 0.
                    timeout_d = 1'b1;
                    state_d   = CMP;
                    ts_d      = '0;
                    if (!rd_ts) id_d = '0;
                end else begin
                    stall_d = stall_q + 16'd1;
                end
            end
            WT_ID, WT_TS: begin
                lat_d = lat_q + 3'd1;
                if (lat_q == LAT_LIM) begin
                    if (rd_ts) ts_d = avm_readdata_i;
                    else       id_d = avm_readdata_i;
                    stall_d = '0;
                    state_d = rd_ts ? CMP : RD_TS;
                end
            end
            CMP: begin
                id_ok_d = !timeout_q && (id_q == EXPECTED_ID);
                ts_ok_d = !timeout_q && (ts_q == EXPECTED_TS);
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o     = (state_q != IDLE) && (state_q != DONE);
    assign done_o     = (state_q == DONE);
    assign id_ok_o    = id_ok_q;
    assign ts_ok_o    = ts_ok_q;
    assign timeout_o  = timeout_q;
    assign id_value_o = id_q;
    assign ts_value_o = ts_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Bench for sysid_checker: three instances (zero-wait, latency 2, short timeout)
// driven by a programmable Avalon slave, results checked against a timing model.
module tb_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'd12345678;
    localparam logic [31:0] EXP_TS = 32'd1432141006;

    logic        clock = 1'b0;
    logic        rst [3];
    logic        st  [3];
    logic        addr[3], rd[3], wr[3];
    logic        busy[3], done[3], idok[3], tsok[3], to[3];
    logic [31:0] rdata[3], idv[3], tsv[3];

    logic [31:0] m0[3], m1[3];
    int          sn0[3], sn1[3];
    int          scnt[3];
    int          acc0[3], acc1[3], stl[3], rd1[3], viol[3];
    bit          pstall[3], paddr[3];
    int          lcnt;
    logic [31:0] hold1;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    sysid_checker #(.READ_LATENCY(0), .TIMEOUT_CYCLES(255), .AUTO_START(1'b1)) u0 (
        .clock_i(clock), .reset_i(rst[0]), .start_i(st[0]),
        .avm_address_o(addr[0]), .avm_read_o(rd[0]), .avm_waitrequest_i(wr[0]),
        .avm_readdata_i(rdata[0]), .busy_o(busy[0]), .done_o(done[0]),
        .id_ok_o(idok[0]), .ts_ok_o(tsok[0]), .timeout_o(to[0]),
        .id_value_o(idv[0]), .ts_value_o(tsv[0]));

    sysid_checker #(.READ_LATENCY(2), .TIMEOUT_CYCLES(255), .AUTO_START(1'b1)) u1 (
        .clock_i(clock), .reset_i(rst[1]), .start_i(st[1]),
        .avm_address_o(addr[1]), .avm_read_o(rd[1]), .avm_waitrequest_i(wr[1]),
        .avm_readdata_i(rdata[1]), .busy_o(busy[1]), .done_o(done[1]),
        .id_ok_o(idok[1]), .ts_ok_o(tsok[1]), .timeout_o(to[1]),
        .id_value_o(idv[1]), .ts_value_o(tsv[1]));

    sysid_checker #(.READ_LATENCY(0), .TIMEOUT_CYCLES(8), .AUTO_START(1'b0)) u2 (
        .clock_i(clock), .reset_i(rst[2]), .start_i(st[2]),
        .avm_address_o(addr[2]), .avm_read_o(rd[2]), .avm_waitrequest_i(wr[2]),
        .avm_readdata_i(rdata[2]), .busy_o(busy[2]), .done_o(done[2]),
        .id_ok_o(idok[2]), .ts_ok_o(tsok[2]), .timeout_o(to[2]),
        .id_value_o(idv[2]), .ts_value_o(tsv[2]));

    // Slave: stalls each read sn0/sn1 cycles; instance 1 presents data only 2 cycles after accept.
    always_comb begin
        for (int k = 0; k < 3; k++)
            wr[k] = rd[k] && (scnt[k] < (addr[k] ? sn1[k] : sn0[k]));
        rdata[0] = rd[0] ? (addr[0] ? m1[0] : m0[0]) : 32'hBAD0_BAD0;
        rdata[2] = rd[2] ? (addr[2] ? m1[2] : m0[2]) : 32'hBAD0_BAD0;
        rdata[1] = (lcnt == 1) ? hold1 : 32'hBAD0_BAD0;
    end

    always @(posedge clock) begin
        for (int k = 0; k < 3; k++) begin
            if (rd[k] && wr[k]) begin
                scnt[k] <= scnt[k] + 1;
                stl[k]  <= stl[k] + 1;
            end else begin
                scnt[k] <= 0;
            end
            if (rd[k] && !wr[k]) begin
                if (addr[k]) acc1[k] <= acc1[k] + 1;
                else         acc0[k] <= acc0[k] + 1;
            end
            if (rd[k] && addr[k]) rd1[k] <= rd1[k] + 1;
            if ((rd[k] && !busy[k]) || (pstall[k] && rd[k] && addr[k] != paddr[k]))
                viol[k] <= viol[k] + 1;
            pstall[k] <= rd[k] && wr[k];
            paddr[k]  <= addr[k];
        end
        if (rd[1] && !wr[1]) begin
            lcnt  <= 2;
            hold1 <= addr[1] ? m1[1] : m0[1];
        end else if (lcnt != 0) begin
            lcnt <= lcnt - 1;
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: a check is launch + per-read (1 + stalls + latency) + compare.
    task automatic model(input logic [31:0] id, input logic [31:0] ts, input int s0, input int s1,
                         input int L, input int TO, output int lat, output logic eid,
                         output logic ets, output logic eto, output logic [31:0] eidv,
                         output logic [31:0] etsv, output int ea0, output int ea1, output int estl);
        if (s0 >= TO) begin
            lat = TO + 2; eto = 1'b1; eidv = 0; etsv = 0; ea0 = 0; ea1 = 0; estl = TO;
        end else if (s1 >= TO) begin
            lat = 3 + s0 + L + TO; eto = 1'b1; eidv = id; etsv = 0; ea0 = 1; ea1 = 0; estl = s0 + TO;
        end else begin
            lat = 4 + s0 + s1 + 2 * L; eto = 1'b0; eidv = id; etsv = ts; ea0 = 1; ea1 = 1;
            estl = s0 + s1;
        end
        eid = !eto && (id == EXP_ID);
        ets = !eto && (ts == EXP_TS);
    endtask

    task automatic run(input int k, input bit rel, input bit extra);
        int L, TO, lat, ea0, ea1, estl, a0, a1, s, r1, v, n;
        logic eid, ets, eto;
        logic [31:0] eidv, etsv;
        bit seen;
        L  = (k == 1) ? 2 : 0;
        TO = (k == 2) ? 8 : 255;
        model(m0[k], m1[k], sn0[k], sn1[k], L, TO, lat, eid, ets, eto, eidv, etsv, ea0, ea1, estl);
        a0 = acc0[k]; a1 = acc1[k]; s = stl[k]; r1 = rd1[k]; v = viol[k];
        if (rel) rst[k] = 1'b0;
        else     st[k] = 1'b1;
        n = 0;
        seen = 0;
        while (!seen && n < 200) begin
            tick;
            n++;
            st[k] = 1'b0;
            if (extra && n == 2) st[k] = 1'b1;
            if (n == 1) begin
                chk("launch_done_clear", done[k], 0);
                chk("launch_busy", busy[k], 1);
            end
            if (done[k]) seen = 1;
        end
        chk("done_latency", n, lat);
        chk("busy_after_done", busy[k], 0);
        chk("id_ok", idok[k], eid);
        chk("ts_ok", tsok[k], ets);
        chk("timeout", to[k], eto);
        chk("id_value", idv[k], eidv);
        chk("ts_value", tsv[k], etsv);
        chk("accepts_addr0", acc0[k] - a0, ea0);
        chk("accepts_addr1", acc1[k] - a1, ea1);
        chk("stalled_cycles", stl[k] - s, estl);
        if (eto && ea0 == 0) chk("no_addr1_read", rd1[k] - r1, 0);
        chk("bus_protocol", viol[k] - v, 0);
    endtask

    initial begin
        int a1, n;
        bit found;
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; st[k] = 1'b0;
            m0[k] = EXP_ID; m1[k] = EXP_TS; sn0[k] = 0; sn1[k] = 0;
        end
        repeat (2) tick;
        for (int k = 0; k < 3; k++) begin
            chk("reset_ctrl", {busy[k], done[k], idok[k], tsok[k], to[k], rd[k], addr[k]}, 0);
            chk("reset_id_value", idv[k], 0);
            chk("reset_ts_value", tsv[k], 0);
        end

        // Auto-start after release on the zero-wait instance; u2 must stay idle.
        rst[2] = 1'b0;
        run(0, 1, 0);
        chk("no_auto_start_idle", {busy[2], done[2], rd[2]}, 0);

        m0[0] = 32'h0000_0001;
        run(0, 0, 0);
        m0[0] = EXP_ID;

        // Stalls of 3 per read with latency 2, launched by auto-start.
        sn0[1] = 3; sn1[1] = 3;
        run(1, 1, 0);
        sn0[1] = 0; sn1[1] = 0;

        // Reset while waiting on timestamp data, then relaunch.
        a1 = acc1[1];
        st[1] = 1'b1;
        tick;
        st[1] = 1'b0;
        found = 0;
        n = 0;
        while (!found && n < 20) begin
            if (busy[1] && !rd[1] && acc1[1] != a1) found = 1;
            else begin tick; n++; end
        end
        chk("reach_wait_ts", found, 1);
        rst[1] = 1'b1;
        tick;
        chk("midcheck_reset_ctrl", {busy[1], done[1], idok[1], tsok[1], to[1], rd[1], addr[1]}, 0);
        chk("midcheck_reset_values", idv[1] | tsv[1], 0);
        run(1, 1, 0);

        // Stuck waitrequest on each address.
        sn0[2] = 1000;
        run(2, 0, 0);
        sn0[2] = 0; sn1[2] = 1000;
        run(2, 0, 0);
        sn1[2] = 0;

        // Start while busy is ignored; start after done reruns.
        run(0, 0, 1);
        run(0, 0, 0);

        // Start coincident with reset loses.
        st[2] = 1'b1; rst[2] = 1'b1;
        tick;
        st[2] = 1'b0; rst[2] = 1'b0;
        chk("reset_beats_start", {busy[2], done[2], rd[2]}, 0);
        repeat (3) tick;
        chk("reset_beats_start_idle", {busy[2], done[2], rd[2]}, 0);

        for (int i = 0; i < 24; i++) begin
            int k;
            k = int'($urandom_range(0, 2));
            m0[k] = $urandom_range(0, 1) ? EXP_ID : $urandom;
            m1[k] = $urandom_range(0, 1) ? EXP_TS : $urandom;
            sn0[k] = int'($urandom_range(0, (k == 2) ? 10 : 3));
            sn1[k] = int'($urandom_range(0, (k == 2) ? 10 : 3));
            run(k, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
